// File: rtl/pps_sync_reset_gen.sv
// PPS-qualified multi-channel synchronous reset generator: measures the GPS PPS interval,
// then releases N_CH staggered resets and starts phase-aligned divided clock enables.
module pps_sync_reset_gen #(
   parameter int unsigned N_CH       = 2,
   parameter int unsigned CLK_HZ     = 32768000,
   parameter int unsigned PPS_TOL    = 64,
   parameter int unsigned RST_CYCLES = 16,
   parameter int unsigned CH_STAGGER = 0,
   parameter int unsigned DIV        = 4,
   parameter bit          REQ_LOCK   = 1'b1
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic            GPS_PPS,
   input  logic            ARM,
   input  logic            MODE,
   output logic [N_CH-1:0] SYNCH_nRST,
   output logic [N_CH-1:0] DIV_EN,
   output logic            PPS_LOCK,
   output logic            PPS_MISSING,
   output logic            BUSY
);
   localparam int unsigned ICNT_SAT = CLK_HZ + PPS_TOL + 1;
   localparam int unsigned IW       = $clog2(CLK_HZ + PPS_TOL + 2);
   localparam int unsigned LAST_REL = RST_CYCLES + (N_CH - 1) * CH_STAGGER;
   localparam int unsigned CW       = $clog2(LAST_REL + 2);
   localparam int unsigned DW       = $clog2(DIV);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_HOLD,
      S_REL,
      S_RUN
   } state_t;

   state_t                   state_q, state_d;
   logic                     pps_meta_q, pps_meta_d;
   logic                     pps_sync_q, pps_sync_d;
   logic                     pps_dly_q, pps_dly_d;
   logic                     edge_q, edge_d;
   logic [IW-1:0]            icnt_q, icnt_d;
   logic                     seen_q, seen_d;
   logic                     lock_q, lock_d;
   logic                     missing_q, missing_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [N_CH-1:0]          nrst_q, nrst_d;
   logic [N_CH-1:0]          div_en_q, div_en_d;
   logic [N_CH-1:0][DW-1:0]  dcnt_q, dcnt_d;
   logic                     busy_q, busy_d;
   logic                     in_win;
   logic                     is_exact;
   logic                     qual;

   // PPS synchronizer, edge register and interval qualification
   always_comb begin : pps_qual_comb
      pps_meta_d = GPS_PPS;
      pps_sync_d = pps_meta_q;
      pps_dly_d  = pps_sync_q;
      edge_d     = pps_sync_q & ~pps_dly_q;
      icnt_d     = icnt_q;
      seen_d     = seen_q;
      lock_d     = lock_q;
      missing_d  = missing_q;
      in_win     = (icnt_q >= IW'(CLK_HZ - PPS_TOL)) && (icnt_q <= IW'(CLK_HZ + PPS_TOL));
      is_exact   = (icnt_q == IW'(CLK_HZ));
      if (edge_q) begin
         icnt_d    = IW'(1);
         seen_d    = 1'b1;
         missing_d = 1'b0;
         if (seen_q) begin
            lock_d = in_win;
         end
      end else if (icnt_q != IW'(ICNT_SAT)) begin
         icnt_d = icnt_q + IW'(1);
         if (icnt_q == IW'(ICNT_SAT - 1)) begin
            missing_d = 1'b1;
            lock_d    = 1'b0;
         end
      end
      qual = edge_q & (lock_d | ~REQ_LOCK);
   end

   always_ff @(posedge CLK) begin : state_reg
      if (!nRST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; cnt counts cycles since the QUAL that entered HOLD
   always_comb begin : fsm_next
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         S_IDLE: if (ARM) state_d = S_WAIT;
         S_WAIT: if (qual) state_d = S_HOLD;
         S_HOLD, S_REL: begin
            if (qual && MODE) begin
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (32'(cnt_q) >= LAST_REL) begin
                  state_d = S_RUN;
               end else if (32'(cnt_d) >= RST_CYCLES) begin
                  state_d = S_REL;
               end else begin
                  state_d = S_HOLD;
               end
            end
         end
         S_RUN: if (qual && MODE && !is_exact) state_d = S_HOLD;
         default: state_d = S_IDLE;
      endcase
   end

   // Registered outputs derived from the next state
   always_comb begin : fsm_out
      busy_d   = (state_d == S_HOLD) || (state_d == S_REL);
      nrst_d   = '0;
      dcnt_d   = '0;
      div_en_d = '0;
      for (int i = 0; i < int'(N_CH); i++) begin
         if (state_d == S_RUN) begin
            nrst_d[i] = 1'b1;
         end else if (busy_d) begin
            nrst_d[i] = 32'(cnt_d) >= (RST_CYCLES + CH_STAGGER * unsigned'(i));
         end
         if (nrst_d[i] && nrst_q[i]) begin
            dcnt_d[i] = (dcnt_q[i] == DW'(DIV - 1)) ? '0 : dcnt_q[i] + DW'(1);
         end
         div_en_d[i] = nrst_d[i] && (dcnt_d[i] == '0);
      end
   end

   always_ff @(posedge CLK) begin : data_reg
      if (!nRST) begin
         pps_meta_q <= 1'b0;
         pps_sync_q <= 1'b0;
         pps_dly_q  <= 1'b0;
         edge_q     <= 1'b0;
         icnt_q     <= '0;
         seen_q     <= 1'b0;
         lock_q     <= 1'b0;
         missing_q  <= 1'b0;
         cnt_q      <= '0;
         nrst_q     <= '0;
         div_en_q   <= '0;
         dcnt_q     <= '0;
         busy_q     <= 1'b0;
      end else begin
         pps_meta_q <= pps_meta_d;
         pps_sync_q <= pps_sync_d;
         pps_dly_q  <= pps_dly_d;
         edge_q     <= edge_d;
         icnt_q     <= icnt_d;
         seen_q     <= seen_d;
         lock_q     <= lock_d;
         missing_q  <= missing_d;
         cnt_q      <= cnt_d;
         nrst_q     <= nrst_d;
         div_en_q   <= div_en_d;
         dcnt_q     <= dcnt_d;
         busy_q     <= busy_d;
      end
   end

   assign SYNCH_nRST  = nrst_q;
   assign DIV_EN      = div_en_q;
   assign PPS_LOCK    = lock_q;
   assign PPS_MISSING = missing_q;
   assign BUSY        = busy_q;

endmodule

// File: tb/tb_pps_sync_reset_gen.sv
// Bench for pps_sync_reset_gen: expected output values are queued against the cycle they
// must appear in and compared when the DUT reaches that cycle.
module tb_pps_sync_reset_gen;
   localparam int unsigned N_CH = 2;
   localparam int S_NRST = 0, S_DIV = 1, S_LOCK = 2, S_MISS = 3, S_BUSY = 4;
   localparam int S_NRST2 = 5, S_BUSY2 = 6, S_DIV2 = 7, S_MISS2 = 8, S_LOCK2 = 9;

   typedef struct {
      int          cyc;
      int          sel;
      int unsigned val;
      string       tag;
   } exp_t;

   logic            clk = 1'b0;
   logic            nrst, gps_pps, arm, mode;
   logic            pps2, arm2;
   logic [N_CH-1:0] synch_nrst, div_en, synch_nrst2, div_en2;
   logic            pps_lock, pps_missing, busy;
   logic            pps_lock2, pps_missing2, busy2;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;

   pps_sync_reset_gen #(
      .N_CH(N_CH), .CLK_HZ(1000), .PPS_TOL(4), .RST_CYCLES(8),
      .CH_STAGGER(4), .DIV(4), .REQ_LOCK(1'b1)
   ) u_dut (
      .CLK(clk), .nRST(nrst), .GPS_PPS(gps_pps), .ARM(arm), .MODE(mode),
      .SYNCH_nRST(synch_nrst), .DIV_EN(div_en), .PPS_LOCK(pps_lock),
      .PPS_MISSING(pps_missing), .BUSY(busy)
   );

   // Same configuration without lock requirement, so two edges can land inside one HOLD
   pps_sync_reset_gen #(
      .N_CH(N_CH), .CLK_HZ(1000), .PPS_TOL(4), .RST_CYCLES(8),
      .CH_STAGGER(4), .DIV(4), .REQ_LOCK(1'b0)
   ) u_dut_nolock (
      .CLK(clk), .nRST(nrst), .GPS_PPS(pps2), .ARM(arm2), .MODE(1'b1),
      .SYNCH_nRST(synch_nrst2), .DIV_EN(div_en2), .PPS_LOCK(pps_lock2),
      .PPS_MISSING(pps_missing2), .BUSY(busy2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp_v);
      n_cmp++;
      if (obs != exp_v) begin
         n_err++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic int unsigned obs_of(input int sel);
      case (sel)
         S_NRST:  return 32'(synch_nrst);
         S_DIV:   return 32'(div_en);
         S_LOCK:  return 32'(pps_lock);
         S_MISS:  return 32'(pps_missing);
         S_BUSY:  return 32'(busy);
         S_NRST2: return 32'(synch_nrst2);
         S_BUSY2: return 32'(busy2);
         S_DIV2:  return 32'(div_en2);
         S_MISS2: return 32'(pps_missing2);
         S_LOCK2: return 32'(pps_lock2);
         default: return 32'hDEAD;
      endcase
   endfunction

   task automatic expect_at(input int c, input int sel, input int unsigned v, input string tag);
      exp_t e;
      int   i;
      e.cyc = c;
      e.sel = sel;
      e.val = v;
      e.tag = tag;
      i = 0;
      while (i < sb.size() && sb[i].cyc <= c) i++;
      sb.insert(i, e);
   endtask

   // Pop every expectation due this cycle and compare it with the sampled output
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         if (e.cyc < cyc) chk($sformatf("%s_late", e.tag), cyc, e.cyc);
         else             chk($sformatf("%s@%0d", e.tag, cyc), obs_of(e.sel), e.val);
      end
   end

   task automatic wait_to(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Raise PPS at the negedge of cycle c; EDGE (and QUAL) fall in cycle c+3
   task automatic pps_edge(input int c);
      wait_to(c);
      gps_pps = 1'b1;
      wait_to(c + 3);
      gps_pps = 1'b0;
   endtask

   task automatic arm_pulse(input int c);
      wait_to(c);
      arm = 1'b1;
      wait_to(c + 1);
      arm = 1'b0;
   endtask

   // Full sync sequence for QUAL in cycle e
   task automatic push_sync(input int e, input string t);
      expect_at(e + 1,  S_NRST, 0, {t, "_hold_nrst"});
      expect_at(e + 1,  S_BUSY, 1, {t, "_hold_busy"});
      expect_at(e + 8,  S_NRST, 0, {t, "_hold_end"});
      expect_at(e + 8,  S_DIV,  0, {t, "_div_pre"});
      expect_at(e + 9,  S_NRST, 1, {t, "_rel_ch0"});
      expect_at(e + 9,  S_DIV,  1, {t, "_div_ch0"});
      expect_at(e + 10, S_DIV,  0, {t, "_div_gap"});
      expect_at(e + 12, S_NRST, 1, {t, "_pre_ch1"});
      expect_at(e + 12, S_BUSY, 1, {t, "_rel_busy"});
      expect_at(e + 13, S_NRST, 3, {t, "_rel_ch1"});
      expect_at(e + 13, S_DIV,  3, {t, "_div_both"});
      expect_at(e + 15, S_BUSY, 0, {t, "_run_busy"});
      expect_at(e + 17, S_DIV,  3, {t, "_div_period"});
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int ea, eb, ec, ed, ef, eg, eh, ei, ek, el, em1, em2, em3;
      nrst = 1'b0; gps_pps = 1'b0; arm = 1'b0; mode = 1'b0; pps2 = 1'b0; arm2 = 1'b0;

      // Reset with PPS toggling
      expect_at(3, S_NRST, 0, "rst_nrst");
      expect_at(3, S_DIV,  0, "rst_div");
      expect_at(3, S_LOCK, 0, "rst_lock");
      expect_at(3, S_MISS, 0, "rst_miss");
      expect_at(3, S_BUSY, 0, "rst_busy");
      expect_at(5, S_NRST, 0, "post_rst_nrst");
      wait_to(1); gps_pps = 1'b1;
      wait_to(2); gps_pps = 1'b0;
      wait_to(3); nrst = 1'b1;

      // First edge, out-of-window 1005, in-window 996 with one-shot sync
      arm_pulse(10);
      ea = 23;
      expect_at(ea + 1, S_LOCK, 0, "first_edge_lock");
      expect_at(ea + 2, S_BUSY, 0, "first_edge_nosync");
      pps_edge(ea - 3);
      eb = ea + 1005;
      expect_at(eb - 1, S_MISS, 0, "pre_sat_miss");
      expect_at(eb,     S_MISS, 1, "sat_miss");
      expect_at(eb + 1, S_MISS, 0, "edge_clr_miss");
      expect_at(eb + 1, S_LOCK, 0, "iv1005_lock");
      expect_at(eb + 2, S_BUSY, 0, "iv1005_nosync");
      pps_edge(eb - 3);
      ec = eb + 996;
      expect_at(ec,     S_LOCK, 0, "pre996_lock");
      expect_at(ec + 1, S_LOCK, 1, "iv996_lock");
      push_sync(ec, "s996");
      pps_edge(ec - 3);
      ed = ec + 1000;
      expect_at(ed + 1, S_LOCK, 1, "iv1000_lock");
      expect_at(ed + 1, S_DIV,  3, "div_phase_long");
      expect_at(ed + 2, S_DIV,  0, "div_phase_gap");
      expect_at(ed + 2, S_BUSY, 0, "oneshot_run");
      pps_edge(ed - 3);
      ef = ed + 1002;
      expect_at(ef + 1, S_LOCK, 1, "iv1002_lock");
      expect_at(ef + 3, S_BUSY, 0, "mode0_ignore");
      expect_at(ef + 3, S_NRST, 3, "mode0_nrst");
      pps_edge(ef - 3);

      // Missing PPS
      expect_at(ef + 1004, S_MISS, 0, "miss_pre");
      expect_at(ef + 1004, S_LOCK, 1, "lock_pre_miss");
      expect_at(ef + 1005, S_MISS, 1, "miss_set");
      expect_at(ef + 1005, S_LOCK, 0, "miss_lock_clr");
      eg = ef + 1100;
      expect_at(eg,     S_MISS, 1, "miss_held");
      expect_at(eg + 1, S_MISS, 0, "miss_edge_clr");
      expect_at(eg + 1, S_LOCK, 0, "miss_edge_lock");
      pps_edge(eg - 3);

      // Qualifying edge during HOLD restarts HOLD (lock-free instance)
      ek = eg + 103;
      el = ek + 5;
      expect_at(ek,     S_MISS2, 1, "nl_miss");
      expect_at(ek + 1, S_MISS2, 0, "nl_miss_clr");
      expect_at(ek + 1, S_NRST2, 0, "nl_hold");
      expect_at(ek + 1, S_BUSY2, 1, "nl_busy");
      expect_at(ek + 9, S_NRST2, 0, "nl_restarted");
      expect_at(ek + 9, S_BUSY2, 1, "nl_busy_restart");
      expect_at(el + 1, S_LOCK2, 0, "nl_lock");
      expect_at(el + 8, S_NRST2, 0, "nl_hold_end");
      expect_at(el + 9, S_NRST2, 1, "nl_rel_ch0");
      expect_at(el + 9, S_DIV2,  1, "nl_div_ch0");
      expect_at(el + 13, S_NRST2, 3, "nl_rel_ch1");
      expect_at(el + 15, S_BUSY2, 0, "nl_run");
      wait_to(eg + 50); arm2 = 1'b1;
      wait_to(eg + 51); arm2 = 1'b0;
      wait_to(ek - 3);  pps2 = 1'b1;
      wait_to(ek - 1);  pps2 = 1'b0;
      wait_to(ek + 2);  pps2 = 1'b1;
      wait_to(ek + 5);  pps2 = 1'b0;

      // Continuous mode: exact interval ignored, drift resyncs
      wait_to(eg + 200); mode = 1'b1;
      eh = eg + 1000;
      expect_at(eh + 1, S_LOCK, 1, "c_iv1000_lock");
      expect_at(eh + 2, S_BUSY, 0, "c_exact_ignore");
      expect_at(eh + 2, S_NRST, 3, "c_exact_nrst");
      pps_edge(eh - 3);
      ei = eh + 1002;
      expect_at(ei,      S_NRST, 3, "c_pre_drift");
      expect_at(ei + 1,  S_NRST, 0, "c_drift_hold");
      expect_at(ei + 1,  S_BUSY, 1, "c_drift_busy");
      expect_at(ei + 8,  S_NRST, 0, "c_hold_end");
      expect_at(ei + 9,  S_NRST, 1, "c_rel_ch0");
      expect_at(ei + 9,  S_DIV,  1, "c_div_ch0");
      expect_at(ei + 10, S_NRST, 1, "c_mid_release");
      // Reset mid-RELEASE aborts
      expect_at(ei + 11, S_NRST, 0, "abort_nrst");
      expect_at(ei + 11, S_BUSY, 0, "abort_busy");
      expect_at(ei + 11, S_LOCK, 0, "abort_lock");
      expect_at(ei + 11, S_DIV,  0, "abort_div");
      expect_at(ei + 14, S_NRST, 0, "abort_no_completion");
      expect_at(ei + 14, S_BUSY, 0, "abort_idle");
      pps_edge(ei - 3);
      wait_to(ei + 10); nrst = 1'b0;
      wait_to(ei + 12); nrst = 1'b1;

      // After reset, sync only once re-armed
      em1 = ei + 50;
      expect_at(em1 + 1, S_LOCK, 0, "post_rst_first_lock");
      pps_edge(em1 - 3);
      em2 = em1 + 1000;
      expect_at(em2 + 1,  S_LOCK, 1, "post_rst_lock");
      expect_at(em2 + 2,  S_BUSY, 0, "no_arm_nosync");
      expect_at(em2 + 10, S_NRST, 0, "no_arm_nrst");
      pps_edge(em2 - 3);
      arm_pulse(em2 + 20);
      em3 = em2 + 1000;
      push_sync(em3, "rearm");
      pps_edge(em3 - 3);

      wait_to(em3 + 30);
      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
